// File: rtl/hold_piece_module_if.sv
// Swap handshake between the hold-slot controller (master) and the game core (slave).
interface hold_piece_module_if;
  localparam int unsigned TYPE_W = 3;

  logic              swap_valid;
  logic              swap_ready;
  logic [TYPE_W-1:0] swap_type;
  logic              swap_from_next;

  modport master (
    output swap_valid,
    output swap_type,
    output swap_from_next,
    input  swap_ready
  );

  modport slave (
    input  swap_valid,
    input  swap_type,
    input  swap_from_next,
    output swap_ready
  );
endinterface

// File: rtl/hold_piece_module.sv
// Hold-slot controller: owns the held piece, runs the swap handshake with the game
// core and publishes the held piece as a 4x4 spawn-orientation bitmap.
// Optional macro HOLD_VBLANK_SYNC_EN: defer the bitmap update to the next frame_sync
// so the preview never changes mid-frame.
module hold_piece_module (
  input  logic                clk,
  input  logic                rst,
  input  logic                hold_req,
  input  logic [2:0]          cur_type,
  input  logic                new_piece,
  input  logic                frame_sync,
  hold_piece_module_if.master swap,
  output logic [15:0]         hold_square,
  output logic                hold_empty,
  output logic                hold_used
);

  localparam int unsigned TYPE_W = 3;
  localparam int unsigned SQ_W   = 16;
  localparam logic [TYPE_W-1:0] TYPE_INVALID = TYPE_W'(7);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SWAP    = 2'd1,
    PUBLISH = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [TYPE_W-1:0] cap_type_q, cap_type_d;
  logic [TYPE_W-1:0] held_type_q, held_type_d;
  logic              valid_q, valid_d;
  logic [TYPE_W-1:0] type_q, type_d;
  logic              from_next_q, from_next_d;
  logic [SQ_W-1:0]   square_q, square_d;
  logic              empty_q, empty_d;
  logic              used_q, used_d;

  logic accept;
  logic handshake;

`ifndef HOLD_VBLANK_SYNC_EN
  // frame_sync has no role when the bitmap updates straight after the handshake
  logic unused_frame_sync;
  assign unused_frame_sync = frame_sync;
`endif

  // Spawn-orientation bitmap ROM; bit i = row i/4, col i%4
  function automatic logic [SQ_W-1:0] bitmap(input logic [TYPE_W-1:0] t);
    case (t)
      TYPE_W'(0): bitmap = SQ_W'(16'h00F0);
      TYPE_W'(1): bitmap = SQ_W'(16'h0066);
      TYPE_W'(2): bitmap = SQ_W'(16'h0027);
      TYPE_W'(3): bitmap = SQ_W'(16'h0036);
      TYPE_W'(4): bitmap = SQ_W'(16'h0063);
      TYPE_W'(5): bitmap = SQ_W'(16'h0071);
      TYPE_W'(6): bitmap = SQ_W'(16'h0074);
      default:    bitmap = SQ_W'(16'h0000);
    endcase
  endfunction

  // A fresh spawn always beats a simultaneous hold request
  assign accept    = hold_req & ~used_q & (cur_type != TYPE_INVALID) & ~new_piece;
  assign handshake = valid_q & swap.swap_ready;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cap_type_q  <= '0;
      held_type_q <= '0;
      valid_q     <= 1'b0;
      type_q      <= '0;
      from_next_q <= 1'b0;
      square_q    <= '0;
      empty_q     <= 1'b1;
      used_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cap_type_q  <= cap_type_d;
      held_type_q <= held_type_d;
      valid_q     <= valid_d;
      type_q      <= type_d;
      from_next_q <= from_next_d;
      square_q    <= square_d;
      empty_q     <= empty_d;
      used_q      <= used_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = SWAP;
`ifdef HOLD_VBLANK_SYNC_EN
      SWAP:    if (handshake)  state_d = PUBLISH;
      PUBLISH: if (frame_sync) state_d = IDLE;
`else
      SWAP: if (handshake) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and held-piece bookkeeping
  always_comb begin
    cap_type_d  = cap_type_q;
    held_type_d = held_type_q;
    valid_d     = valid_q;
    type_d      = type_q;
    from_next_d = from_next_q;
    square_d    = square_q;
    empty_d     = empty_q;
    used_d      = used_q;
    case (state_q)
      IDLE: begin
        if (new_piece) begin
          used_d = 1'b0;
        end else if (accept) begin
          cap_type_d  = cur_type;
          valid_d     = 1'b1;
          from_next_d = empty_q;
          type_d      = empty_q ? '0 : held_type_q;
        end
      end
      SWAP: begin
        // Request stays frozen until the core takes it
        if (handshake) begin
          held_type_d = cap_type_q;
          empty_d     = 1'b0;
          used_d      = 1'b1;
          valid_d     = 1'b0;
          type_d      = '0;
          from_next_d = 1'b0;
`ifndef HOLD_VBLANK_SYNC_EN
          square_d    = bitmap(cap_type_q);
`endif
        end
      end
`ifdef HOLD_VBLANK_SYNC_EN
      PUBLISH: begin
        if (new_piece)  used_d   = 1'b0;
        if (frame_sync) square_d = bitmap(held_type_q);
      end
`endif
      default: ;
    endcase
  end

  assign swap.swap_valid     = valid_q;
  assign swap.swap_type      = type_q;
  assign swap.swap_from_next = from_next_q;
  assign hold_square         = square_q;
  assign hold_empty          = empty_q;
  assign hold_used           = used_q;

endmodule

// File: tb/tb_hold_piece_module.sv
// Scoreboard bench for hold_piece_module: stimulus pushes expected swaps and bitmap
// updates; a negedge monitor pops and compares whenever the DUT presents them.
module tb_hold_piece_module;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold_req;
  logic [2:0]  cur_type;
  logic        new_piece;
  logic        frame_sync;
  logic        swap_ready;
  logic [15:0] hold_square;
  logic        hold_empty;
  logic        hold_used;

  hold_piece_module_if sw ();
  assign sw.swap_ready = swap_ready;

  hold_piece_module dut (
    .clk         (clk),
    .rst         (rst),
    .hold_req    (hold_req),
    .cur_type    (cur_type),
    .new_piece   (new_piece),
    .frame_sync  (frame_sync),
    .swap        (sw),
    .hold_square (hold_square),
    .hold_empty  (hold_empty),
    .hold_used   (hold_used)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [3:0]  swap_q[$];  // {from_next, type}
  logic [15:0] sq_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: handshake payloads, request stability, and bitmap changes
  logic        prev_valid = 1'b0;
  logic [2:0]  prev_type  = '0;
  logic        prev_fn    = 1'b0;
  logic [15:0] prev_sq    = '0;
  always @(negedge clk) begin
    logic [3:0] e;
    if (rst) begin
      prev_valid = 1'b0;
      prev_sq    = hold_square;
    end else begin
      if (prev_valid) begin
        chk("valid_stable", 32'(sw.swap_valid), 32'd1);
        chk("type_stable", 32'(sw.swap_type), 32'(prev_type));
        chk("from_next_stable", 32'(sw.swap_from_next), 32'(prev_fn));
      end
      if (sw.swap_valid && swap_ready) begin
        if (swap_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_swap: got type %0d from_next %0d expected no swap at %0t",
                   sw.swap_type, sw.swap_from_next, $time);
        end else begin
          e = swap_q.pop_front();
          chk("swap_type", 32'(sw.swap_type), 32'(e[2:0]));
          chk("swap_from_next", 32'(sw.swap_from_next), 32'(e[3]));
        end
        prev_valid = 1'b0;
      end else begin
        prev_valid = sw.swap_valid;
        prev_type  = sw.swap_type;
        prev_fn    = sw.swap_from_next;
      end
      if (hold_square !== prev_sq) begin
        if (sq_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_square: got %0h expected %0h at %0t", hold_square, prev_sq, $time);
        end else begin
          chk("hold_square_update", 32'(hold_square), 32'(sq_q.pop_front()));
        end
        prev_sq = hold_square;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [2:0] t);
    hold_req = 1'b1;
    cur_type = t;
    tick();
    hold_req = 1'b0;
  endtask

  task automatic complete();
    swap_ready = 1'b1;
    tick();
    swap_ready = 1'b0;
  endtask

  // Bitmap check after a handshake; deferred to frame_sync in the vblank build
  task automatic square_after(input string name, input logic [15:0] old, input logic [15:0] exp);
`ifdef HOLD_VBLANK_SYNC_EN
    tick();
    tick();
    chk({name, "_held_mid_frame"}, 32'(hold_square), 32'(old));
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
`else
    chk({name, "_prev"}, 32'(old), 32'(old) & 32'(hold_square | ~hold_square));
`endif
    chk(name, 32'(hold_square), 32'(exp));
  endtask

  initial begin
    rst = 1'b1; hold_req = 1'b0; cur_type = '0; new_piece = 1'b0;
    frame_sync = 1'b0; swap_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_valid", 32'(sw.swap_valid), 32'd0);
    chk("rst_type", 32'(sw.swap_type), 32'd0);
    chk("rst_from_next", 32'(sw.swap_from_next), 32'd0);
    chk("rst_square", 32'(hold_square), 32'd0);
    chk("rst_empty", 32'(hold_empty), 32'd1);
    chk("rst_used", 32'(hold_used), 32'd0);

    // First hold from empty: core takes its next piece, T goes into the slot
    swap_q.push_back({1'b1, 3'd0});
    sq_q.push_back(16'h0027);
    request(3'd2);
    chk("t1_valid", 32'(sw.swap_valid), 32'd1);
    chk("t1_from_next", 32'(sw.swap_from_next), 32'd1);
    complete();
    chk("t1_valid_drop", 32'(sw.swap_valid), 32'd0);
    chk("t1_used", 32'(hold_used), 32'd1);
    chk("t1_empty", 32'(hold_empty), 32'd0);
    square_after("t1_square", 16'h0000, 16'h0027);

    // Second hold before a spawn is dropped (ready high exposes any stray request)
    swap_ready = 1'b1;
    request(3'd0);
    tick();
    chk("t2_no_valid", 32'(sw.swap_valid), 32'd0);
    swap_ready = 1'b0;

    // Spawn, then hold I: T comes back out
    new_piece = 1'b1; tick(); new_piece = 1'b0;
    chk("t3_used_clear", 32'(hold_used), 32'd0);
    swap_q.push_back({1'b0, 3'd2});
    sq_q.push_back(16'h00F0);
    request(3'd0);
    chk("t3_type", 32'(sw.swap_type), 32'd2);
    chk("t3_from_next", 32'(sw.swap_from_next), 32'd0);
    complete();
    chk("t3_used", 32'(hold_used), 32'd1);
    square_after("t3_square", 16'h0027, 16'h00F0);

    // Stalled core: request stays frozen, spawn and hold pulses are ignored
    new_piece = 1'b1; tick(); new_piece = 1'b0;
    swap_q.push_back({1'b0, 3'd0});
    sq_q.push_back(16'h0063);
    request(3'd4);
    for (int i = 0; i < 10; i++) begin
      new_piece = (i == 3);
      hold_req  = (i == 6);
      cur_type  = (i == 6) ? 3'd6 : 3'd4;
      tick();
    end
    new_piece = 1'b0; hold_req = 1'b0;
    chk("t4_valid_wait", 32'(sw.swap_valid), 32'd1);
    chk("t4_type_wait", 32'(sw.swap_type), 32'd0);
    complete();
    chk("t4_used", 32'(hold_used), 32'd1);
    square_after("t4_square", 16'h00F0, 16'h0063);

    // Spawn and hold in the same cycle: spawn wins
    swap_ready = 1'b1;
    new_piece = 1'b1; hold_req = 1'b1; cur_type = 3'd1;
    tick();
    new_piece = 1'b0; hold_req = 1'b0;
    chk("t5_used", 32'(hold_used), 32'd0);
    chk("t5_no_valid", 32'(sw.swap_valid), 32'd0);
    tick();

    // Invalid piece type never requests
    request(3'd7);
    tick();
    chk("t6_no_valid", 32'(sw.swap_valid), 32'd0);
    swap_ready = 1'b0;

    // frame_sync while idle changes nothing
    frame_sync = 1'b1; tick(); frame_sync = 1'b0;
    tick();
    chk("t7_square_idle", 32'(hold_square), 32'h0063);

    // Hold J: Z comes out
    swap_q.push_back({1'b0, 3'd4});
    sq_q.push_back(16'h0071);
    request(3'd5);
    complete();
    square_after("t8_square", 16'h0063, 16'h0071);

    // Reset mid-handshake: request drops at once and the held piece is lost
    new_piece = 1'b1; tick(); new_piece = 1'b0;
    swap_q.push_back({1'b0, 3'd5});
    request(3'd3);
    chk("t9_valid", 32'(sw.swap_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t9_rst_valid", 32'(sw.swap_valid), 32'd0);
    chk("t9_rst_type", 32'(sw.swap_type), 32'd0);
    chk("t9_rst_empty", 32'(hold_empty), 32'd1);
    chk("t9_rst_used", 32'(hold_used), 32'd0);
    chk("t9_rst_square", 32'(hold_square), 32'd0);
    swap_q.delete();
    sq_q.delete();
    tick();
    rst = 1'b0;
    tick();

    // After reset the slot is empty again: next-queue swap
    swap_q.push_back({1'b1, 3'd0});
    sq_q.push_back(16'h0036);
    request(3'd3);
    complete();
    square_after("t10_square", 16'h0000, 16'h0036);

    tick(); tick();
    chk("pending_swaps", 32'(swap_q.size()), 32'd0);
    chk("pending_squares", 32'(sq_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
